// File: rtl/duck_round_ctl.sv
// Round/shot sequencer: click edge detect, hit test, shot/hit/duck counters, flight timers, respawn.
// Latency: a click or frame_tick acts at the next clk edge; outputs are decoded from registered state.
// Backpressure: none; game_enable low forces IDLE. Build option DUCK_BONUS_EN doubles first-shot points.
module duck_round_ctl #(
    parameter int DUCK_WIDTH      = 64,
    parameter int DUCK_HEIGHT     = 64,
    parameter int SHOTS_PER_DUCK  = 3,
    parameter int DUCKS_PER_ROUND = 10,
    parameter int FLY_FRAMES      = 300,
    parameter int FALL_FRAMES     = 60,
    parameter int POINTS_PER_HIT  = 100
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        game_enable,
    input  logic        frame_tick,
    input  logic        left_mouse,
    input  logic [11:0] mouse_xpos,
    input  logic [11:0] mouse_ypos,
    input  logic [11:0] duck_xpos,
    input  logic [11:0] duck_ypos,
    output logic        duck_respawn,
    output logic        duck_shot,
    output logic [1:0]  shots_left,
    output logic [3:0]  ducks_hit,
    output logic [3:0]  duck_count,
    output logic [15:0] score,
    output logic        game_finished
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SPAWN,
        S_FLY,
        S_HIT,
        S_ESCAPE,
        S_NEXT,
        S_DONE
    } state_t;

    state_t      state;
    state_t      state_nxt;

    logic        left_prev;
    logic        click;
    logic        shot_fired;
    logic        hit;
    logic        fly_timeout;
    logic        fall_done;
    logic [15:0] frame_cnt;

    // 13-bit hit-box bounds so a duck near the right/bottom edge cannot wrap
    logic [12:0] box_x_hi;
    logic [12:0] box_y_hi;
    logic [16:0] hit_points;
    logic [17:0] score_sum;

    assign click      = left_mouse & ~left_prev;
    assign shot_fired = click && (shots_left != 2'd0);

    assign box_x_hi = {1'b0, duck_xpos} + 13'(DUCK_WIDTH - 1);
    assign box_y_hi = {1'b0, duck_ypos} + 13'(DUCK_HEIGHT - 1);
    assign hit = ({1'b0, mouse_xpos} >= {1'b0, duck_xpos}) && ({1'b0, mouse_xpos} <= box_x_hi) &&
                 ({1'b0, mouse_ypos} >= {1'b0, duck_ypos}) && ({1'b0, mouse_ypos} <= box_y_hi);

    assign fly_timeout = frame_tick && (frame_cnt == 16'(FLY_FRAMES - 1));
    assign fall_done   = frame_tick && (frame_cnt == 16'(FALL_FRAMES - 1));

`ifdef DUCK_BONUS_EN
    // First-shot hits (no shot spent yet on this duck) score double
    assign hit_points = (shots_left == 2'(SHOTS_PER_DUCK)) ? 17'(2 * POINTS_PER_HIT)
                                                           : 17'(POINTS_PER_HIT);
`else
    assign hit_points = 17'(POINTS_PER_HIT);
`endif

    assign score_sum = {2'b00, score} + {1'b0, hit_points};

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode and state-decoded outputs; a click outranks a same-cycle flight timeout
    always_comb begin
        state_nxt     = state;
        duck_respawn  = 1'b0;
        duck_shot     = 1'b0;
        game_finished = 1'b0;
        case (state)
            S_IDLE: begin
                state_nxt = S_SPAWN;
            end
            S_SPAWN: begin
                duck_respawn = 1'b1;
                state_nxt    = S_FLY;
            end
            S_FLY: begin
                if (shot_fired && hit) begin
                    state_nxt = S_HIT;
                end else if (shot_fired && (shots_left == 2'd1)) begin
                    state_nxt = S_ESCAPE;
                end else if (fly_timeout) begin
                    state_nxt = S_ESCAPE;
                end
            end
            S_HIT: begin
                duck_shot = 1'b1;
                if (fall_done) begin
                    state_nxt = S_NEXT;
                end
            end
            S_ESCAPE: begin
                if (fall_done) begin
                    state_nxt = S_NEXT;
                end
            end
            S_NEXT: begin
                state_nxt = (duck_count >= 4'(DUCKS_PER_ROUND)) ? S_DONE : S_SPAWN;
            end
            S_DONE: begin
                game_finished = 1'b1;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
        if (!game_enable) begin
            state_nxt = S_IDLE;
        end
    end

    // Click edge register, frame timer and game counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            left_prev  <= 1'b0;
            frame_cnt  <= 16'd0;
            shots_left <= 2'd0;
            ducks_hit  <= 4'd0;
            duck_count <= 4'd0;
            score      <= 16'd0;
        end else begin
            left_prev <= left_mouse;

            // Timer restarts on every state change so each state counts its own ticks
            if (state_nxt != state) begin
                frame_cnt <= 16'd0;
            end else if (frame_tick) begin
                frame_cnt <= frame_cnt + 16'd1;
            end

            if (!game_enable || (state == S_IDLE)) begin
                shots_left <= 2'd0;
                ducks_hit  <= 4'd0;
                duck_count <= 4'd0;
                score      <= 16'd0;
            end else if (state == S_SPAWN) begin
                shots_left <= 2'(SHOTS_PER_DUCK);
                if (duck_count < 4'(DUCKS_PER_ROUND)) begin
                    duck_count <= duck_count + 4'd1;
                end
            end else if ((state == S_FLY) && shot_fired) begin
                shots_left <= shots_left - 2'd1;
                if (hit) begin
                    if (ducks_hit < duck_count) begin
                        ducks_hit <= ducks_hit + 4'd1;
                    end
                    score <= (score_sum > 18'h0FFFF) ? 16'hFFFF : score_sum[15:0];
                end
            end
        end
    end

endmodule
